// File: rtl/audio_dma_pkg.sv
// Shared types and constants for the Wishbone audio DMA block.
package audio_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } dma_state_t;

    localparam int          SAMPLE_W   = 8;
    localparam logic [3:0]  WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/wb_audio_dma.sv
// Wishbone read master streaming 8-bit samples into a FIFO, played out as PWM.
// Define AUDIO_DMA_LOOP_EN to honour i_loop (restart from base after last word).
module wb_audio_dma
    import audio_dma_pkg::*;
#(
    parameter int clk_freq_hz    = 50000000,
    parameter int sample_rate_hz = 48000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_base_adr,
    input  logic [15:0] i_len,
    input  logic        i_loop,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_underrun,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_pwm,
    output logic        o_aud_sd
);

    localparam int DIV = clk_freq_hz / sample_rate_hz;
    localparam int TW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    dma_state_t            r_state;
    logic [31:0]           r_adr;
    logic [15:0]           r_remain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_cyc;
`ifdef AUDIO_DMA_LOOP_EN
    logic [31:0]           r_base;
    logic [15:0]           r_len;
    logic                  r_loop;
`endif

    logic [TW-1:0]         r_tick_cnt;
    logic [7:0]            r_pwm_cnt;
    logic [SAMPLE_W-1:0]   r_cur_sample;
    logic                  r_pwm;
    logic                  r_underrun;

    logic                  w_tick;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_last;
    logic [SAMPLE_W-1:0]   w_fifo_dout;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_unused;

    assign w_tick  = (r_tick_cnt == TW'(DIV - 1));
    assign w_push  = (r_state == REQ) && i_wb_ack && !i_wb_err;
    assign w_flush = (r_state == REQ) && i_wb_err;
    assign w_pop   = w_tick && !w_fifo_empty && !w_flush;
    assign w_last  = (r_remain == 16'd1);

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (i_wb_rdt[SAMPLE_W-1:0]),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cyc    <= 1'b0;
`ifdef AUDIO_DMA_LOOP_EN
            r_base   <= '0;
            r_len    <= '0;
            r_loop   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_err    <= 1'b0;
                        r_adr    <= {i_base_adr[31:2], 2'b00};
                        r_remain <= i_len;
`ifdef AUDIO_DMA_LOOP_EN
                        r_base   <= {i_base_adr[31:2], 2'b00};
                        r_len    <= i_len;
                        r_loop   <= i_loop;
`endif
                        if (i_len == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_cyc   <= 1'b1;
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_wb_err) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_state <= IDLE;
                    end else if (i_wb_ack) begin
                        // HOLD doubles as the mandatory idle cycle between requests.
                        r_cyc <= 1'b0;
`ifdef AUDIO_DMA_LOOP_EN
                        if (w_last && r_loop) begin
                            r_adr    <= r_base;
                            r_remain <= r_len;
                            r_state  <= HOLD;
                        end else
`endif
                        if (w_last) begin
                            r_remain <= '0;
                            r_state  <= DRAIN;
                        end else begin
                            r_adr    <= r_adr + 32'd4;
                            r_remain <= r_remain - 16'd1;
                            r_state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_fifo_count < CW'(FIFO_DEPTH)) begin
                        r_cyc   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Playback counters run regardless of transfer state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt   <= '0;
            r_pwm_cnt    <= '0;
            r_cur_sample <= '0;
            r_pwm        <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
            r_underrun <= w_tick && w_fifo_empty && r_busy;
            if (w_pop) r_cur_sample <= w_fifo_dout;
            r_pwm <= (r_pwm_cnt < r_cur_sample);
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_underrun = r_underrun;
    assign o_wb_adr   = r_adr;
    assign o_wb_dat   = 32'd0;
    assign o_wb_sel   = WB_SEL_ALL;
    assign o_wb_we    = 1'b0;
    assign o_wb_cyc   = r_cyc;
    assign o_wb_stb   = r_cyc;
    assign o_pwm      = r_pwm;
    assign o_aud_sd   = r_busy;

`ifdef AUDIO_DMA_LOOP_EN
    assign w_unused = &{1'b0, i_base_adr[1:0], i_wb_rdt[31:SAMPLE_W], w_fifo_full};
`else
    assign w_unused = &{1'b0, i_base_adr[1:0], i_wb_rdt[31:SAMPLE_W], w_fifo_full, i_loop};
`endif

endmodule

// File: tb/tb_wb_audio_dma.sv
// Directed bench for wb_audio_dma: DIV=256, FIFO_DEPTH=4, zero-wait memory slave.
module tb_wb_audio_dma;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_loop;
    logic [31:0] i_base_adr;
    logic [15:0] i_len;
    logic        o_busy, o_done, o_err, o_underrun;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack, i_wb_err;
    logic        o_pwm, o_aud_sd;

    always #5 clk = ~clk;

    wb_audio_dma #(
        .clk_freq_hz    (256000),
        .sample_rate_hz (1000),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_base_adr (i_base_adr),
        .i_len      (i_len),
        .i_loop     (i_loop),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_underrun (o_underrun),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_pwm      (o_pwm),
        .o_aud_sd   (o_aud_sd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory slave: byte sample per word, combinational response.
    logic [7:0]  mem [64];
    logic        ack_en = 1'b1;
    int          err_at = -1;
    int          rd_cnt = 0;
    logic [31:0] rd_log [64];

    assign i_wb_ack = o_wb_cyc && o_wb_stb && ack_en && (rd_cnt != err_at);
    assign i_wb_err = o_wb_cyc && o_wb_stb && ack_en && (rd_cnt == err_at);
    assign i_wb_rdt = {24'h0, mem[o_wb_adr[7:2]]};

    always @(posedge clk) begin
        if (i_wb_ack || i_wb_err) begin
            if (rd_cnt < 64) rd_log[rd_cnt] <= o_wb_adr;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Phase model: tick and PWM counters both restart at reset and run mod 256.
    logic [7:0] ph = 8'd0;
    always @(posedge clk) ph <= i_rst ? 8'd0 : ph + 8'd1;

    int done_cnt = 0, und_cnt = 0, cyc_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (o_done === 1'b1)     done_cnt <= done_cnt + 1;
        if (o_underrun === 1'b1) und_cnt  <= und_cnt + 1;
        if (o_wb_cyc === 1'b1)   cyc_cnt  <= cyc_cnt + 1;
        if (o_busy === 1'b1)     busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ph(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph != 8'(v) && n < 600);
        check("wait_ph", {24'h0, ph}, 32'(v));
    endtask

    // Count o_pwm highs over the 256 cycles that reflect one sample period.
    task automatic measure(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) @(negedge clk);
            hi += int'(o_pwm);
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len, input logic lp);
        i_base_adr = base;
        i_len      = len;
        i_loop     = lp;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
    endtask

    int hi, r0, d0, u0, c0, b0, n;
    int exp_duty [3] = '{0, 128, 255};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
        mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'hFF;
        for (int i = 0; i < 10; i++) mem[16 + i] = 8'(8'h10 * i + 8'h07);
        mem[32] = 8'h3C;
        mem[48] = 8'h5A;

        i_rst = 1'b1; i_start = 1'b0; i_loop = 1'b0;
        i_base_adr = '0; i_len = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", {24'h0, o_wb_cyc, o_wb_stb, o_busy, o_done, o_err, o_underrun, o_pwm, o_aud_sd}, 32'h0);
        check("rst_adr", o_wb_adr, 32'h0);
        check("const_bus", {o_wb_dat[27:0], o_wb_sel, o_wb_we, 3'b000}, {28'h0, 4'hF, 4'h0});
        i_rst = 1'b0;

        // len=3 from 0x100, samples 00/80/FF
        wait_ph(10);
        u0 = und_cnt; d0 = done_cnt; r0 = rd_cnt;
        do_start(32'h100, 16'd3, 1'b0);
        check("t1_cyc_T1", {31'h0, o_wb_cyc}, 32'd1);
        check("t1_adr0", o_wb_adr, 32'h100);
        check("t1_busy_sd", {30'h0, o_busy, o_aud_sd}, 32'd3);
        @(negedge clk);
        check("t1_gap", {31'h0, o_wb_cyc}, 32'd0);
        @(negedge clk);
        check("t1_cyc_T3", {31'h0, o_wb_stb}, 32'd1);
        check("t1_adr1", o_wb_adr, 32'h104);
        for (int k = 0; k < 3; k++) begin
            wait_ph(1);
            measure(hi);
            check("t1_duty", 32'(hi), 32'(exp_duty[k]));
        end
        @(negedge clk);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_no_underrun", 32'(und_cnt - u0), 32'd0);
        check("t1_idle", {31'h0, o_busy}, 32'd0);
        check("t1_nreads", 32'(rd_cnt - r0), 32'd3);
        for (int k = 0; k < 3; k++) check("t1_addr", rd_log[r0 + k], 32'h100 + 32'(4 * k));

        // len=0: done next cycle, no bus activity
        wait_ph(30);
        c0 = cyc_cnt; b0 = busy_cnt;
        do_start(32'h100, 16'd0, 1'b0);
        check("t2_done", {29'h0, o_done, o_busy, o_wb_cyc}, 32'd4);
        @(negedge clk);
        check("t2_done_pulse", {31'h0, o_done}, 32'd0);
        repeat (3) @(negedge clk);
        check("t2_no_cyc", 32'(cyc_cnt - c0), 32'd0);
        check("t2_no_busy", 32'(busy_cnt - b0), 32'd0);

        // len=10 with depth-4 FIFO: stalls in HOLD, one refill per tick
        wait_ph(10);
        u0 = und_cnt; d0 = done_cnt; r0 = rd_cnt;
        do_start(32'h140, 16'd10, 1'b0);
        wait_ph(200);
        check("t3_hold_cyc", {31'h0, o_wb_cyc}, 32'd0);
        check("t3_hold_reads", 32'(rd_cnt - r0), 32'd4);
        for (int i = 0; i < 10; i++) begin
            wait_ph(1);
            measure(hi);
            check("t3_sample", 32'(hi), {24'h0, mem[16 + i]});
            check("t3_reads", 32'(rd_cnt - r0), (i < 5) ? 32'(5 + i) : 32'd10);
        end
        check("t3_done_once", 32'(done_cnt - d0), 32'd1);
        check("t3_no_underrun", 32'(und_cnt - u0), 32'd0);
        check("t3_idle", {31'h0, o_busy}, 32'd0);
        for (int k = 0; k < 10; k++) check("t3_addr", rd_log[r0 + k], 32'h140 + 32'(4 * k));

        // bus error on second read
        wait_ph(10);
        u0 = und_cnt;
        err_at = rd_cnt + 1;
        do_start(32'h180, 16'd5, 1'b0);
        check("t4_adr0", o_wb_adr, 32'h180);
        @(negedge clk);
        @(negedge clk);
        check("t4_req2", {31'h0, o_wb_cyc}, 32'd1);
        check("t4_adr1", o_wb_adr, 32'h184);
        @(negedge clk);
        check("t4_abort", {28'h0, o_wb_cyc, o_err, o_done, o_busy}, 32'b0110);
        @(negedge clk);
        check("t4_sticky", {30'h0, o_err, o_done}, 32'b10);
        err_at = -1;
        wait_ph(20);
        do_start(32'h100, 16'd0, 1'b0);
        check("t4_err_clear", {30'h0, o_err, o_done}, 32'b01);
        wait_ph(1);
        measure(hi);
        check("t4_flushed_hold", 32'(hi), 32'h97);
        check("t4_no_underrun", 32'(und_cnt - u0), 32'd0);

        // first word lands on the tick edge: underrun pulse
        wait_ph(254);
        u0 = und_cnt; d0 = done_cnt;
        do_start(32'h1C0, 16'd1, 1'b0);
        check("t5_cyc", {31'h0, o_wb_cyc}, 32'd1);
        @(negedge clk);
        check("t5_underrun", {31'h0, o_underrun}, 32'd1);
        @(negedge clk);
        check("t5_underrun_pulse", {31'h0, o_underrun}, 32'd0);
        measure(hi);
        check("t5_held_sample", 32'(hi), 32'h97);
        wait_ph(1);
        measure(hi);
        check("t5_sample", 32'(hi), 32'h5A);
        check("t5_und_once", 32'(und_cnt - u0), 32'd1);
        check("t5_done_once", 32'(done_cnt - d0), 32'd1);

`ifdef AUDIO_DMA_LOOP_EN
        wait_ph(10);
        r0 = rd_cnt; d0 = done_cnt;
        do_start(32'h100, 16'd2, 1'b1);
        n = 0;
        while (rd_cnt - r0 < 6 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("t6_reads", {31'h0, (rd_cnt - r0 >= 6)}, 32'd1);
        for (int k = 0; k < 6; k++) check("t6_addr", rd_log[r0 + k], 32'h100 + 32'(4 * (k % 2)));
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_busy", {31'h0, o_busy}, 32'd1);
        ack_en = 1'b0;
`else
        ack_en = 1'b0;
        do_start(32'h100, 16'd5, 1'b0);
`endif
        // reset while a request is outstanding
        n = 0;
        while (o_wb_cyc !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("t7_req_held", {30'h0, o_wb_cyc, o_wb_stb}, 32'd3);
        i_rst = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        check("t7_rst_outs", {24'h0, o_wb_cyc, o_wb_stb, o_busy, o_done, o_err, o_underrun, o_pwm, o_aud_sd}, 32'h0);
        check("t7_rst_adr", o_wb_adr, 32'h0);
        i_rst = 1'b0;
        wait_ph(1);
        measure(hi);
        check("t7_sample_cleared", 32'(hi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_audio_dma.md
# wb_audio_dma

Wishbone classic read master that streams 8-bit audio samples from system memory into an on-chip FIFO and plays them out as PWM at a fixed sample rate. It sits beside the register-mapped audio peripheral on the SweRVolf interconnect. It acts as the initiator, so the CPU only programs base/length/start and no longer pokes samples through MMIO.

## Interface
- clk_freq_hz, 50000000, system clock frequency in Hz
- sample_rate_hz, 48000, playback rate; tick divider DIV = clk_freq_hz/sample_rate_hz (integer, ≥ 256)
- FIFO_DEPTH, 8, sample FIFO entries, power of two, ≥ 2

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse, begin transfer
- i_base_adr  in  32  byte address of first word, bits [1:0] ignored
- i_len  in  16  number of 32-bit words to fetch
- i_loop  in  1  restart from base after last word
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse at end of transfer or abort
- o_err  out  1  sticky bus error, cleared by next accepted start
- o_underrun  out  1  one-cycle pulse, sample tick with empty FIFO
- o_wb_adr  out  32  byte address
- o_wb_dat  out  32  constant 0
- o_wb_sel  out  4  constant 4'hF
- o_wb_we  out  1  constant 0
- o_wb_cyc, o_wb_stb  out  1  bus request
- i_wb_rdt  in  32  read data; sample = bits [7:0]
- i_wb_ack, i_wb_err  in  1  slave response
- o_pwm  out  1  PWM audio
- o_aud_sd  out  1  audio amp enable, equals o_busy

## Operation
- FSM states: IDLE, REQ, HOLD, DRAIN.
- IDLE: i_start latches base, len, loop; clears o_err; sets o_busy. len = 0 → o_done next cycle, stays IDLE, no bus cycle. i_start ignored in every other state.
- REQ: cyc=stb=1, adr = current. Held until ack or err.
  - On ack: push i_wb_rdt[7:0], adr += 4, remaining −= 1, drop cyc/stb for one cycle.
  - remaining hits 0 with loop set → adr = base, remaining = len, continue. Without loop → DRAIN.
- HOLD: entered instead of REQ when FIFO count == FIFO_DEPTH. Returns to REQ when count < FIFO_DEPTH. At most one outstanding request, so an ack never overflows the FIFO.
- DRAIN: no bus activity. When FIFO is empty: o_done pulse, o_busy = 0, → IDLE.
- i_wb_err in REQ: set o_err, flush FIFO, o_done pulse, → IDLE.
- Playback:
  - Free-running tick counter 0..DIV−1. On tick: pop FIFO into cur_sample, or raise o_underrun and hold cur_sample if FIFO is empty while o_busy.
  - 8-bit PWM counter free-running; o_pwm = (pwm_cnt < cur_sample), registered.
  - cur_sample 0 → constant low; 255 → high 255/256.
- A FIFO push and pop in the same cycle leaves count unchanged.

## Timing
- Reset values: all outputs 0, cur_sample 0, FIFO empty, state IDLE. Reset mid-transfer drops cyc/stb at the next edge regardless of ack.
- i_start at cycle T → cyc/stb high at T+1.
- Ack at cycle A → data in FIFO at A+1, next stb at A+2 (one idle cycle between requests).
- o_pwm lags pwm_cnt by 1 cycle. Popped sample takes effect at the tick cycle + 1.
- o_done is a single cycle, coincident with o_busy falling.

## Configuration
- AUDIO_DMA_LOOP_EN defined: i_loop honoured as above.
- Undefined: i_loop ignored, the loop register and wrap logic are absent, and every transfer ends in DRAIN.

## Structure
- Package audio_dma_pkg holds:
  - FSM state encoding (IDLE, REQ, HOLD, DRAIN)
  - SAMPLE_W = 8
  - WB_SEL_ALL = 4'hF
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports push, pop, din, dout, count, full, empty, flush
  - pointer wrap modulo DEPTH
- Top level holds the FSM, address/length counters, tick divider and PWM.

## Test plan
- len=3, base=0x100, zero-wait slave → reads at 0x100, 0x104, 0x108, then DRAIN. o_done once FIFO empties after 3 ticks; no underrun.
- len=0 → o_done at T+1, o_busy never high, cyc never asserted.
- FIFO_DEPTH=4, len=10, ticks slow → FSM enters HOLD after 4 words; count never exceeds 4; all 10 samples played in address order.
- Samples 0x00, 0x80, 0xFF → o_pwm high 0, 128, 255 of each 256-cycle period.
- i_wb_err on 2nd read → o_err=1, o_done pulse, FIFO flushed, cyc low next cycle. A following i_start clears o_err.
- With AUDIO_DMA_LOOP_EN, len=2, loop=1 → address sequence 0x100, 0x104, 0x100, 0x104…; o_done never pulses. Assert i_rst mid-REQ → cyc=0 next cycle, all outputs 0.
